// File: rtl/fft_wb_addr_seq.sv
// Write-back sequencer for the 16-point radix-4 FFT: serialises each butterfly result into four memory writes.
// Build option FFT_WB_NATURAL_ORDER_EN: stage-1 writes land in natural order instead of in-place.
module fft_wb_addr_seq #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*DATA_W-1:0] in_c,
  input  logic [2*DATA_W-1:0] in_d,
  output logic                mem_we,
  output logic [3:0]          mem_waddr,
  output logic [2*DATA_W-1:0] mem_wdata,
  output logic                stage,
  output logic [1:0]          butterfly,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                stage_q, stage_d;
  logic [1:0]          bfly_q, bfly_d;
  logic [1:0]          lane_q, lane_d;
  logic [2*DATA_W-1:0] buf_q [4];
  logic [2*DATA_W-1:0] buf_d [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= 1'b0;
      bfly_q  <= 2'd0;
      lane_q  <= 2'd0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    lane_d    = lane_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = 4'd0;
    mem_wdata = '0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          stage_d = 1'b0;
          bfly_d  = 2'd0;
          lane_d  = 2'd0;
        end
      end

      ST_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d[0] = in_a;
          buf_d[1] = in_b;
          buf_d[2] = in_c;
          buf_d[3] = in_d;
          lane_d   = 2'd0;
          state_d  = ST_WRITE;
        end
      end

      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = buf_q[lane_q];
        // Stage 0 strides by 4 across lanes; stage 1 is either contiguous (in-place) or strided (natural order).
`ifdef FFT_WB_NATURAL_ORDER_EN
        mem_waddr = {lane_q, bfly_q};
`else
        mem_waddr = stage_q ? {bfly_q, lane_q} : {lane_q, bfly_q};
`endif
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          if (stage_q && (bfly_q == 2'd3)) begin
            state_d = ST_DONE;
          end else begin
            bfly_d  = bfly_q + 2'd1;
            if (bfly_q == 2'd3) stage_d = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign stage     = stage_q;
  assign butterfly = bfly_q;

endmodule

// File: doc/fft_wb_addr_seq.md
# fft_wb_addr_seq

Write-back sequencer for the 16-point radix-4 FFT datapath. Accepts one butterfly result (four complex outputs A–D) per handshake and serialises it into four single-port data-memory writes at the in-place addresses for the current stage/butterfly. Owns the stage/butterfly counters that drive the read-address LUT, and signals completion after stage 1, butterfly 3.

## Interface
- DATA_W, 16, width of each real/imag component; a complex word is {re, im} = 2*DATA_W bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transform (accepted only in IDLE)
- in_valid  in  1  butterfly result valid
- in_ready  out  1  sequencer can accept a butterfly result
- in_a, in_b, in_c, in_d  in  2*DATA_W each  butterfly outputs, {re, im}
- mem_we  out  1  data-memory write enable
- mem_waddr  out  4  data-memory write address
- mem_wdata  out  2*DATA_W  data-memory write data
- stage  out  1  current stage (0 or 1), to the read-address LUT
- butterfly  out  2  current butterfly (0–3), to the read-address LUT
- busy  out  1  transform in progress (not IDLE)
- done  out  1  one-cycle pulse at transform completion

## Operation
- States: IDLE, WAIT, WRITE, DONE.
- IDLE: in_ready=0, busy=0. start=1 → WAIT; stage, butterfly and lane are cleared.
- WAIT: in_ready=1. When in_valid && in_ready, capture in_a..in_d into a 4-word holding buffer; go to WRITE with lane=0.
- WRITE: in_ready=0, mem_we=1, mem_wdata = buffered word[lane] (lane 0=A … 3=D). Lane increments every cycle; after lane 3:
  - if stage=1 and butterfly=3 → DONE;
  - else butterfly+1 (on wrap 3→0, stage becomes 1) → WAIT.
- DONE: done=1 for one cycle, then IDLE; stage/butterfly are held until the next start.
- Address rule, stage 0: mem_waddr = butterfly + 4*lane (A=b, B=b+4, C=b+8, D=b+12).
- Address rule, stage 1: mem_waddr = 4*butterfly + lane (in-place); see Configuration.
- All address arithmetic is 4-bit unsigned with no overflow possible; data is passed through unmodified.
- start outside IDLE is ignored. in_valid outside WAIT is ignored, and no data is captured.
- Inputs must be stable only in the capture cycle; the buffer decouples them afterwards.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, stage=0, butterfly=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-transform aborts immediately; pending buffered writes are discarded, with no write and no done.
- start at cycle T → busy=1 and in_ready=1 at T+1.
- Handshake at cycle T → mem_we=1 for T+1..T+4 (lanes 0..3).
  - Non-final butterfly: in_ready=1 again at T+5.
  - Final butterfly: done=1 at T+5, busy=0 at T+6.
- Throughput: one butterfly per 5 cycles. A minimum transform is 1 + 8×5 cycles from start to done.
- stage/butterfly update in the cycle WRITE→WAIT; they are stable throughout WAIT and WRITE for a given butterfly.

## Configuration
- FFT_WB_NATURAL_ORDER_EN defined: stage-1 writes use mem_waddr = butterfly + 4*lane. This produces natural-order X[k] at address k, so no digit-reversed unload is needed.
- Undefined: stage-1 writes use in-place 4*butterfly + lane. Output is digit-reversed in memory. Stage-0 behaviour is identical in both builds.

## Test plan
- Reset/idle: hold rst_n=0, then release with no start → all outputs 0, in_ready=0 indefinitely; in_valid pulses cause no mem_we.
- Full transform: start, then present 8 butterflies with in_valid held high. Data is in_a=0x0001_0000+n, b=+0x10, c=+0x20, d=+0x30 for butterfly n.
  - Stage-0 writes: 0,4,8,12 / 1,5,9,13 / 2,6,10,14 / 3,7,11,15.
  - Stage-1 writes (default build): 0..15 sequential.
  - done pulses exactly once, 5 cycles after the 8th handshake.
- Natural-order build: same stimulus with FFT_WB_NATURAL_ORDER_EN defined → stage-1 butterfly 1 writes addresses 1,5,9,13; butterfly 3 writes 3,7,11,15.
- Backpressure: in_valid low for 3 cycles in WAIT → no writes, and stage/butterfly hold. A stray in_valid during WRITE is not captured, and the write count stays at 32 per transform.
- Start ignored: pulse start during WRITE of stage 0, butterfly 2 → counters are not cleared and the sequence completes normally.
- Reset mid-op: assert rst_n=0 during lane 1 of stage 1, butterfly 1 → mem_we=0 immediately and all outputs return to reset values. A new start runs a complete fresh transform from stage 0, butterfly 0.
